// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared types and constants for the mul/div sequencer.
// Op kinds, FSM states, stall and unit handshake levels.
package muldiv_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_kind_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_BUSY = 2'b01,
    S_DIV_BUSY = 2'b10,
    S_DONE     = 2'b11
  } state_e;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic UNIT_START = 1'b1;
  localparam logic UNIT_STOP  = 1'b0;
  localparam logic UNIT_READY = 1'b1;

  function automatic logic is_div(input op_kind_e k);
    return (k == OP_DIV) || (k == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Busy-cycle counter with a MAX_CYCLES compare.
// Ports: clr_i restarts, cnt_en_i counts, arm_i gates fire_o.
module muldiv_watchdog #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic cnt_en_i,
  input  logic arm_i,
  output logic fire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fire_o = cnt_en_i & arm_i &
                  (cnt_q == CNT_W'(MAX_CYCLES));

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer between EX and the iterative mul/div units.
// Ports: EX request/stall/result, mul_* and div_* unit handshakes.
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_kind,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        stallreq,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        timeout_err,
  output logic        mul_start,
  output logic        mul_signed,
  output logic        mul_annul,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic        mul_ready,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  state_e      state_q;
  op_kind_e    kind_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic     mul_busy;
  logic     div_busy;
  logic     busy;
  logic     rdy_sel;
  logic     accept;
  logic     wd_fire;
  op_kind_e kind_in;

  assign kind_in  = op_kind_e'(op_kind);
  assign mul_busy = (state_q == S_MUL_BUSY);
  assign div_busy = (state_q == S_DIV_BUSY);
  assign busy     = mul_busy | div_busy;
  assign rdy_sel  = (mul_busy & (mul_ready == UNIT_READY)) |
                    (div_busy & (div_ready == UNIT_READY));
  assign accept   = (state_q == S_IDLE) & op_valid & ~flush;

  // Ready wins over the watchdog; flush wins over both.
  muldiv_watchdog #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept),
    .cnt_en_i(busy),
    .arm_i   (~rst & ~flush & ~rdy_sel),
    .fire_o  (wd_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= OP_MULT;
      src1_q  <= '0;
      src2_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            src1_q <= op_src1;
            src2_q <= op_src2;
            kind_q <= kind_in;
            if (is_div(kind_in) && (op_src2 == 32'd0)) begin
              hi_q    <= op_src1;
              lo_q    <= 32'hFFFF_FFFF;
              state_q <= S_DONE;
            end else if (is_div(kind_in)) begin
              state_q <= S_DIV_BUSY;
            end else begin
              state_q <= S_MUL_BUSY;
            end
          end
        end
        S_MUL_BUSY, S_DIV_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (rdy_sel) begin
            {hi_q, lo_q} <= mul_busy ? mul_result
                                     : div_result;
            state_q <= S_DONE;
          end else if (wd_fire) begin
            hi_q    <= '0;
            lo_q    <= '0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || ex_advance) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallreq = (~rst & ~flush &
                     ((state_q == S_IDLE & op_valid) | busy))
                    ? STOP : NO_STOP;

  assign result_valid = (state_q == S_DONE);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;
  assign timeout_err  = wd_fire;

  assign mul_start  = mul_busy ? UNIT_START : UNIT_STOP;
  assign mul_signed = mul_busy & (kind_q == OP_MULT);
  assign mul_annul  = mul_busy & ~rst & (flush | wd_fire);
  assign mul_op1    = mul_busy ? src1_q : '0;
  assign mul_op2    = mul_busy ? src2_q : '0;

  assign div_start  = div_busy ? UNIT_START : UNIT_STOP;
  assign div_signed = div_busy & (kind_q == OP_DIV);
  assign div_annul  = div_busy & ~rst & (flush | wd_fire);
  assign div_op1    = div_busy ? src1_q : '0;
  assign div_op2    = div_busy ? src2_q : '0;

endmodule
